// File: rtl/ham_dec_arb_pkg.sv
// Shared helpers and response type for the shared Hamming-decoder arbiter.
// Encoded words are numbered [DATA_WIDTH:1]; bit DATA_WIDTH is the overall parity.
package ham_pkg;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int calc_pw(input int data_width);
    return $clog2(data_width);
  endfunction

  function automatic int calc_dw(input int data_width);
    return data_width - 1 - $clog2(data_width);
  endfunction

  // Word position of the k-th payload bit (k from 1): the k-th non-power-of-two index.
  function automatic int data_pos(input int k);
    int n;
    int pos;
    n   = 0;
    pos = 0;
    for (int p = 1; p < 256; p++) begin
      if (!is_pow2(p) && pos == 0) begin
        n++;
        if (n == k) pos = p;
      end
    end
    return pos;
  endfunction

  localparam int DEF_DATA_WIDTH = 7;
  localparam int DEF_DW         = calc_dw(DEF_DATA_WIDTH);

  typedef struct packed {
    logic [DEF_DW:1] data;
    logic            dbit_err;
  } rsp_t;

endpackage

// File: rtl/ham_dec_arb_if.sv
// Request/response bus between the requesters and the decoder arbiter.
interface ham_dec_arb_if
  import ham_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 7
);
  localparam int DW = calc_dw(DATA_WIDTH);

  logic [N_REQ-1:0]            i_req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] i_req_word;
  logic [N_REQ-1:0]            o_req_ready;
  logic [N_REQ-1:0]            o_rsp_valid;
  logic [N_REQ*DW-1:0]         o_rsp_data;
  logic [N_REQ-1:0]            o_rsp_dbit_err;
  logic [N_REQ-1:0]            i_rsp_ready;

  modport slave (
    input  i_req_valid, i_req_word, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_dbit_err
  );

  modport master (
    output i_req_valid, i_req_word, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_dbit_err
  );
endinterface

// File: rtl/ham_dec_arb_dec.sv
// Dual-lane SEC-DED Hamming decoder: corrects single-bit errors, flags double-bit errors.
module ham_dual_dec
  import ham_pkg::*;
#(
  parameter int DATA_WIDTH = 7,
  localparam int DW        = calc_dw(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH:1] i_word_a,
  input  logic [DATA_WIDTH:1] i_word_b,
  output logic [DW:1]         o_data_a,
  output logic [DW:1]         o_data_b,
  output logic                o_dbit_a,
  output logic                o_dbit_b
);
  localparam int PW = calc_pw(DATA_WIDTH);

  logic [1:0][DATA_WIDTH:1] w_word;
  logic [1:0][DW:1]         w_data;
  logic [1:0]               w_dbit;

  assign w_word[0] = i_word_a;
  assign w_word[1] = i_word_b;

  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [PW-1:0] w_syn;
    logic          w_par;

    // Syndrome is the XOR of the positions of all set bits below the overall parity.
    always_comb begin
      w_syn = '0;
      for (int p = 1; p < DATA_WIDTH; p++) begin
        if (w_word[l][p]) w_syn = w_syn ^ PW'(p);
      end
    end

    assign w_par     = ^w_word[l];
    assign w_dbit[l] = (w_syn != '0) && !w_par;

    for (genvar k = 1; k <= DW; k++) begin : g_bit
      localparam int P = data_pos(k);
      assign w_data[l][k] = w_word[l][P] ^ (w_par && (w_syn == PW'(P)));
    end
  end

  assign o_data_a = w_data[0];
  assign o_data_b = w_data[1];
  assign o_dbit_a = w_dbit[0];
  assign o_dbit_b = w_dbit[1];
endmodule

// File: rtl/ham_dec_arb_pick2.sv
// Combinational round-robin picker: first two eligible requesters at or after the pointer.
module ham_rr_pick2
  import ham_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_elig,
  input  logic [IW-1:0]    i_ptr,
  output logic             o_a_vld,
  output logic [IW-1:0]    o_a_idx,
  output logic             o_b_vld,
  output logic [IW-1:0]    o_b_idx
);
  logic [N_REQ-1:0] w_rot;

  // Bit k of w_rot is requester (ptr+k) mod N_REQ, valid for any N_REQ.
  assign w_rot = N_REQ'({i_elig, i_elig} >> i_ptr);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IW'(s);
  endfunction

  always_comb begin
    o_a_vld = 1'b0;
    o_a_idx = '0;
    o_b_vld = 1'b0;
    o_b_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_rot[k]) begin
        if (!o_a_vld) begin
          o_a_vld = 1'b1;
          o_a_idx = wrap_idx(i_ptr, k);
        end else if (!o_b_vld) begin
          o_b_vld = 1'b1;
          o_b_idx = wrap_idx(i_ptr, k);
        end
      end
    end
  end
endmodule

// File: rtl/ham_dec_arb.sv
// Shares one dual-lane Hamming decoder among N_REQ requesters with round-robin grants,
// per-requester response slots and a saturating double-bit-error counter.
module ham_dec_arb
  import ham_pkg::*;
#(
  parameter int DATA_WIDTH = 7,
  parameter int N_REQ      = 4,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_cnt_clr,
  ham_dec_arb_if.slave     bus,
  output logic [CNT_W-1:0] o_dbit_cnt,
  output logic [1:0]       o_lane_busy
);
  localparam int DW = calc_dw(DATA_WIDTH);
  localparam int IW = $clog2(N_REQ);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(inc);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic [IW-1:0]            r_ptr;
  logic [CNT_W-1:0]         r_dbit_cnt;
  logic [N_REQ-1:0]         r_vld_p1;
  logic [N_REQ-1:0][DW:1]   r_data_p1;
  logic [N_REQ-1:0]         r_dbit_p1;

  logic [N_REQ-1:0]         w_elig;
  logic [N_REQ-1:0]         w_sel_a;
  logic [N_REQ-1:0]         w_sel_b;
  logic                     w_a_vld;
  logic                     w_b_vld;
  logic [IW-1:0]            w_a_idx;
  logic [IW-1:0]            w_b_idx;
  logic [IW-1:0]            w_ptr_last;
  logic [IW-1:0]            w_ptr_nxt;
  logic [DATA_WIDTH:1]      w_word_a;
  logic [DATA_WIDTH:1]      w_word_b;
  logic [DW:1]              w_data_a;
  logic [DW:1]              w_data_b;
  logic                     w_dbit_a;
  logic                     w_dbit_b;
  logic [1:0]               w_inc;

  // Stage p0: eligibility, grant and decode, all within the grant cycle.
  assign w_elig = bus.i_req_valid & (~r_vld_p1 | bus.i_rsp_ready) & {N_REQ{i_en & i_rst_n}};

  ham_rr_pick2 #(.N_REQ(N_REQ)) u_pick (
    .i_elig  (w_elig),
    .i_ptr   (r_ptr),
    .o_a_vld (w_a_vld),
    .o_a_idx (w_a_idx),
    .o_b_vld (w_b_vld),
    .o_b_idx (w_b_idx)
  );

  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_word_a = '0;
    w_word_b = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (w_a_vld && w_a_idx == IW'(r)) begin
        w_sel_a[r] = 1'b1;
        w_word_a   = bus.i_req_word[r*DATA_WIDTH +: DATA_WIDTH];
      end
      if (w_b_vld && w_b_idx == IW'(r)) begin
        w_sel_b[r] = 1'b1;
        w_word_b   = bus.i_req_word[r*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  ham_dual_dec #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
    .i_word_a (w_word_a),
    .i_word_b (w_word_b),
    .o_data_a (w_data_a),
    .o_data_b (w_data_b),
    .o_dbit_a (w_dbit_a),
    .o_dbit_b (w_dbit_b)
  );

  assign w_inc      = {1'b0, w_a_vld & w_dbit_a} + {1'b0, w_b_vld & w_dbit_b};
  assign w_ptr_last = w_b_vld ? w_b_idx : w_a_idx;
  assign w_ptr_nxt  = (w_ptr_last == IW'(N_REQ - 1)) ? '0 : w_ptr_last + IW'(1);

  // Stage p1: response slots; a load in the same cycle as a drain keeps the slot full.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr      <= '0;
      r_dbit_cnt <= '0;
      r_vld_p1   <= '0;
      r_data_p1  <= '0;
      r_dbit_p1  <= '0;
    end else begin
      if (w_a_vld) r_ptr <= w_ptr_nxt;
      r_dbit_cnt <= i_cnt_clr ? '0 : sat_add(r_dbit_cnt, w_inc);
      for (int r = 0; r < N_REQ; r++) begin
        if (w_sel_a[r]) begin
          r_vld_p1[r]  <= 1'b1;
          r_data_p1[r] <= w_data_a;
          r_dbit_p1[r] <= w_dbit_a;
        end else if (w_sel_b[r]) begin
          r_vld_p1[r]  <= 1'b1;
          r_data_p1[r] <= w_data_b;
          r_dbit_p1[r] <= w_dbit_b;
        end else if (bus.i_rsp_ready[r]) begin
          r_vld_p1[r]  <= 1'b0;
        end
      end
    end
  end

  assign bus.o_req_ready    = w_sel_a | w_sel_b;
  assign bus.o_rsp_valid    = r_vld_p1;
  assign bus.o_rsp_data     = r_data_p1;
  assign bus.o_rsp_dbit_err = r_dbit_p1;
  assign o_dbit_cnt         = r_dbit_cnt;
  assign o_lane_busy        = {w_b_vld, w_a_vld};
endmodule
